// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC engine, one sample per clock, full-circle angles.
// Each sample carries its own mode bit (0 = rotation, 1 = vectoring) and a user tag.
// Stage P (input register) applies a quadrant pre-rotation; stages 1..I run
// iterations j = 0..I-1; stage I is the output register. One global enable moves
// the whole pipeline, so results leave in acceptance order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready = ~out_valid | out_ready)
//   in_mode, in_tag       per-sample mode and opaque tag
//   in_x, in_y            signed N-bit inputs
//   in_z                  signed binary angle, 2^N == 2*pi
//   out_valid/out_ready   output handshake
//   out_x, out_y          signed N+2-bit results (include CORDIC gain ~1.6468)
//   out_z                 signed N-bit binary-angle result
//   out_mode, out_tag     mode and tag travelling with the result
module cordic_pipe #(
  parameter int N     = 16,
  parameter int I     = 16,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [N-1:0]     in_x,
  input  logic signed [N-1:0]     in_y,
  input  logic signed [N-1:0]     in_z,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N+1:0]     out_x,
  output logic signed [N+1:0]     out_y,
  output logic signed [N-1:0]     out_z,
  output logic                    out_mode,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int          W       = N + 2;
  localparam int          RSH     = 32 - N;
  // Half-LSB of the N-bit angle expressed in the 32-bit table scale (zero when N == 32).
  localparam logic [32:0] RND     = (N < 32) ? (33'd1 << (RSH - 1)) : 33'd0;
  localparam logic [N-1:0] QUARTER = {2'b01, {(N-2){1'b0}}};

  // atan(2^-j) * 2^32 / (2*pi), rounded to nearest.
  function automatic logic [31:0] atan32(input logic [4:0] j);
    case (j)
      5'd0:    atan32 = 32'h20000000;
      5'd1:    atan32 = 32'h12E4051E;
      5'd2:    atan32 = 32'h09FB385B;
      5'd3:    atan32 = 32'h051111D4;
      5'd4:    atan32 = 32'h028B0D43;
      5'd5:    atan32 = 32'h0145D7E1;
      5'd6:    atan32 = 32'h00A2F61E;
      5'd7:    atan32 = 32'h00517C55;
      5'd8:    atan32 = 32'h0028BE53;
      5'd9:    atan32 = 32'h00145F2F;
      5'd10:   atan32 = 32'h000A2F98;
      5'd11:   atan32 = 32'h000517CC;
      5'd12:   atan32 = 32'h00028BE6;
      5'd13:   atan32 = 32'h000145F3;
      5'd14:   atan32 = 32'h0000A2FA;
      5'd15:   atan32 = 32'h0000517D;
      5'd16:   atan32 = 32'h000028BE;
      5'd17:   atan32 = 32'h0000145F;
      5'd18:   atan32 = 32'h00000A30;
      5'd19:   atan32 = 32'h00000518;
      5'd20:   atan32 = 32'h0000028C;
      5'd21:   atan32 = 32'h00000146;
      5'd22:   atan32 = 32'h000000A3;
      5'd23:   atan32 = 32'h00000051;
      5'd24:   atan32 = 32'h00000029;
      5'd25:   atan32 = 32'h00000014;
      5'd26:   atan32 = 32'h0000000A;
      5'd27:   atan32 = 32'h00000005;
      5'd28:   atan32 = 32'h00000003;
      5'd29:   atan32 = 32'h00000001;
      5'd30:   atan32 = 32'h00000001;
      default: atan32 = 32'h00000000;
    endcase
  endfunction

  // Table entry rounded to the N-bit angle width.
  function automatic logic [N-1:0] atan_n(input logic [4:0] j);
    logic [32:0] sum;
    logic [32:0] shifted;
    sum     = {1'b0, atan32(j)} + RND;
    shifted = sum >> RSH;
    atan_n  = shifted[N-1:0];
  endfunction

  // Stage 0 is P, stage I is the output register.
  logic signed [W-1:0] x_r [0:I];
  logic signed [W-1:0] y_r [0:I];
  logic [N-1:0]        z_r [0:I];
  logic [TAG_W-1:0]    t_r [0:I];
  logic [I:0]          m_r;
  logic [I:0]          v_r;

  logic                adv_s;
  logic signed [W-1:0] ext_x_s;
  logic signed [W-1:0] ext_y_s;
  logic signed [W-1:0] pre_x_s;
  logic signed [W-1:0] pre_y_s;
  logic [N-1:0]        pre_z_s;

  // Next values for stage k+1, computed from stage k.
  logic signed [W-1:0] nx_s  [0:I-1];
  logic signed [W-1:0] ny_s  [0:I-1];
  logic [N-1:0]        nz_s  [0:I-1];
  logic signed [W-1:0] xsh_s [0:I-1];
  logic signed [W-1:0] ysh_s [0:I-1];
  logic [I-1:0]        dpos_s;

  // The whole pipeline moves when the output slot is empty or being drained.
  assign adv_s    = ~v_r[I] | out_ready;
  assign in_ready = adv_s;

  assign ext_x_s = {{2{in_x[N-1]}}, in_x};
  assign ext_y_s = {{2{in_y[N-1]}}, in_y};

  // Quadrant pre-rotation by +/-90 degrees so the iterations only see +/-90 degree residuals.
  always_comb begin
    pre_x_s = ext_x_s;
    pre_y_s = ext_y_s;
    pre_z_s = in_z;
    if (in_mode == 1'b0) begin
      case (in_z[N-1:N-2])
        2'b01: begin
          pre_x_s = -ext_y_s;
          pre_y_s = ext_x_s;
          pre_z_s = in_z - QUARTER;
        end
        2'b10: begin
          pre_x_s = ext_y_s;
          pre_y_s = -ext_x_s;
          pre_z_s = in_z + QUARTER;
        end
        default: begin
          pre_x_s = ext_x_s;
          pre_y_s = ext_y_s;
          pre_z_s = in_z;
        end
      endcase
    end else begin
      if (ext_x_s[W-1] && !ext_y_s[W-1]) begin
        pre_x_s = ext_y_s;
        pre_y_s = -ext_x_s;
        pre_z_s = in_z + QUARTER;
      end else if (ext_x_s[W-1] && ext_y_s[W-1]) begin
        pre_x_s = -ext_y_s;
        pre_y_s = ext_x_s;
        pre_z_s = in_z - QUARTER;
      end else begin
        pre_x_s = ext_x_s;
        pre_y_s = ext_y_s;
        pre_z_s = in_z;
      end
    end
  end

  // Micro-rotation datapath for every iteration stage; direction chosen per sample mode.
  always_comb begin
    for (int k = 0; k < I; k++) begin
      dpos_s[k] = (~m_r[k] & ~z_r[k][N-1]) | (m_r[k] & y_r[k][W-1]);
      xsh_s[k]  = x_r[k] >>> k;
      ysh_s[k]  = y_r[k] >>> k;
      if (dpos_s[k]) begin
        nx_s[k] = x_r[k] - ysh_s[k];
        ny_s[k] = y_r[k] + xsh_s[k];
        nz_s[k] = z_r[k] - atan_n(5'(k));
      end else begin
        nx_s[k] = x_r[k] + ysh_s[k];
        ny_s[k] = y_r[k] - xsh_s[k];
        nz_s[k] = z_r[k] + atan_n(5'(k));
      end
    end
  end

  // Pipeline registers: all stages load together on adv, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
      m_r <= '0;
      for (int k = 0; k <= I; k++) begin
        x_r[k] <= '0;
        y_r[k] <= '0;
        z_r[k] <= '0;
        t_r[k] <= '0;
      end
    end else if (adv_s) begin
      v_r[0] <= in_valid;
      m_r[0] <= in_mode;
      x_r[0] <= pre_x_s;
      y_r[0] <= pre_y_s;
      z_r[0] <= pre_z_s;
      t_r[0] <= in_tag;
      for (int k = 0; k < I; k++) begin
        v_r[k+1] <= v_r[k];
        m_r[k+1] <= m_r[k];
        x_r[k+1] <= nx_s[k];
        y_r[k+1] <= ny_s[k];
        z_r[k+1] <= nz_s[k];
        t_r[k+1] <= t_r[k];
      end
    end
  end

  assign out_valid = v_r[I];
  assign out_mode  = m_r[I];
  assign out_x     = x_r[I];
  assign out_y     = y_r[I];
  assign out_z     = z_r[I];
  assign out_tag   = t_r[I];

endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe (N=16, I=16): directed steps in one initial block,
// a floating-point reference model feeding a scoreboard queue at acceptance,
// and a negedge monitor popping and comparing at each output handshake.
module tb_cordic_pipe;

  localparam int N      = 16;
  localparam int I      = 16;
  localparam int TW     = 4;
  localparam int LAT    = I + 1;
  localparam int TOL_XY = 16;
  localparam int TOL_Z  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  in_mode = 1'b0;
  logic signed [N-1:0]   in_x = '0;
  logic signed [N-1:0]   in_y = '0;
  logic signed [N-1:0]   in_z = '0;
  logic [TW-1:0]         in_tag = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [N+1:0]   out_x;
  logic signed [N+1:0]   out_y;
  logic signed [N-1:0]   out_z;
  logic                  out_mode;
  logic [TW-1:0]         out_tag;

  cordic_pipe #(.N(N), .I(I), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            ex;
    int            ey;
    int            ez;
    bit            mode;
    logic [TW-1:0] tag;
    int            acc;
    bit            chk_lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          lat_on = 1'b1;
  bit          rnd_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [56:0] prev_bus = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_near(string tag, int obs, int expv, int tol);
    int d;
    d = obs - expv;
    total++;
    assert ((d >= -tol && d <= tol) === 1'b1) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (+/-%0d)", tag, obs, expv, tol);
    end
  endtask

  function automatic int wrapn(int v);
    logic signed [N-1:0] t;
    t = v[N-1:0];
    return int'(t);
  endfunction

  // Ideal CORDIC result: exact rotation/vectoring scaled by the I-iteration gain.
  function automatic exp_t model(bit mode, int x, int y, int z, logic [TW-1:0] tag);
    exp_t e;
    real  k, th, pi;
    pi = 3.14159265358979;
    k  = 1.0;
    for (int j = 0; j < I; j++) k = k * $sqrt(1.0 + 2.0 ** (-2 * j));
    if (!mode) begin
      th   = real'(z) * 2.0 * pi / 65536.0;
      e.ex = int'(k * (real'(x) * $cos(th) - real'(y) * $sin(th)));
      e.ey = int'(k * (real'(x) * $sin(th) + real'(y) * $cos(th)));
      e.ez = 0;
    end else begin
      e.ex = int'(k * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      e.ey = 0;
      e.ez = wrapn(z + int'($atan2(real'(y), real'(x)) * 65536.0 / (2.0 * pi)));
    end
    e.mode    = mode;
    e.tag     = tag;
    e.acc     = cyc;
    e.chk_lat = lat_on;
    return e;
  endfunction

  // Monitor: stall stability, scoreboard pop/compare, and push on acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {out_x, out_y, out_z, out_mode, out_tag}, prev_bus);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk_near("out_x", int'(out_x), mon_e.ex, TOL_XY);
          chk_near("out_y", int'(out_y), mon_e.ey, TOL_XY);
          chk_near("out_z", wrapn(int'(out_z) - mon_e.ez), 0, TOL_Z);
          chk("out_mode", out_mode, mon_e.mode);
          chk("out_tag", out_tag, mon_e.tag);
          if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc, LAT);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_bus   = {out_x, out_y, out_z, out_mode, out_tag};
      if (in_valid && in_ready)
        sbq.push_back(model(in_mode, int'(in_x), int'(in_y), int'(in_z), in_tag));
    end
  end

  task automatic send(bit mode, int x, int y, int z, int tag);
    bit acc;
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_z     = 16'(z);
    in_tag   = 4'(tag);
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(1, 0));
      n++;
    end while (!acc && n < 200);
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 1000) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(1, 0));
      n++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  function automatic int rmag(int lo, int hi);
    int m;
    m = int'($urandom_range(hi, lo));
    return ($urandom_range(1, 0) == 1) ? m : -m;
  endfunction

  task automatic chk_reset_outputs(string pfx);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_x"}, out_x, 0);
    chk({pfx, "_out_y"}, out_y, 0);
    chk({pfx, "_out_z"}, out_z, 0);
    chk({pfx, "_out_mode"}, out_mode, 0);
    chk({pfx, "_out_tag"}, out_tag, 0);
    chk({pfx, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rotation, zero angle.
    send(1'b0, 16384, 0, 0, 1);
    drain();

    // Rotation around the circle: +90, -180 (wrap corner), +45.
    send(1'b0, 16384, 0, 16'h4000, 2);
    send(1'b0, 16384, 0, -32768, 3);
    send(1'b0, 16384, 0, 16'h2000, 4);
    drain();

    // Vectoring in the second and third quadrants.
    send(1'b1, -10000, 10000, 0, 5);
    send(1'b1, -10000, -10000, 0, 6);
    drain();

    // Mixed back-to-back stream, alternating mode, cycling tags.
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) send(1'b0, rmag(1000, 10000), rmag(1000, 10000), int'($urandom_range(65535, 0)), k % 16);
      else            send(1'b1, rmag(4000, 20000), rmag(4000, 20000), int'($urandom_range(65535, 0)), k % 16);
    end
    drain();

    // Backpressure: fill all I+1 stages, hold 10 cycles, then random out_ready.
    lat_on    = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < LAT; k++) send(k[0], rmag(4000, 10000), rmag(4000, 10000), int'($urandom_range(65535, 0)), k % 16);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_x     = 16'sd1234;
    in_y     = -16'sd4321;
    in_z     = 16'sd1000;
    in_tag   = 4'd9;
    repeat (10) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    rnd_ready = 1'b1;
    for (int k = 0; k < 12; k++) send(k[0], rmag(4000, 10000), rmag(4000, 10000), int'($urandom_range(65535, 0)), (k + 3) % 16);
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    lat_on    = 1'b1;

    // Reset with the pipeline full and a valid output presented.
    for (int k = 0; k < 25; k++) send(k[0], rmag(4000, 10000), rmag(4000, 10000), int'($urandom_range(65535, 0)), k % 16);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sbq.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    send(1'b0, 16384, 0, 16'h2000, 11);
    send(1'b1, -10000, 10000, 0, 12);
    send(1'b0, 16384, 0, 16'h4000, 13);
    drain();

    // Nothing stale may appear after the queue is empty.
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("final_sb_empty", sbq.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
